round_controller: RTL and testbench
===================================

Name: round_controller

Overview:
- Sequences one game of the binary-counting game.
- Draws a target from the free-running 8-bit LFSR value, presents it to the display/input logic and times the player's answer.
- Judges each submission, keeps score and lives, and ends the game when lives run out.
- Sits between the random number generator, the debounced button/switch logic and the display driver.

Parameters:
- LIVES, 3, lives at game start (1..7).
- ROUND_TICKS, 200, timer ticks allowed per round (1..255).
- SHOW_TICKS, 50, timer ticks the result is held before the next round (1..255).
- DRAW_TRIES, 8, rejected LFSR samples tolerated before the fallback target is used.
- MIN_TICKS, 40, lower bound on round time; used only with ROUND_SPEEDUP_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse, begins a game
- tick  in  1  single-cycle timebase strobe (e.g. 100 Hz enable)
- rnd  in  8  current LFSR value
- user_value  in  8  player's switch value
- submit  in  1  single-cycle pulse, player commits user_value
- target  out  8  current target number
- round_active  out  1  high while an answer is accepted
- time_left  out  8  remaining ticks in round
- result_valid  out  1  high while the result is shown
- correct  out  1  last judgement (1 = correct); meaningful when result_valid=1
- score  out  8  correct answers this game, saturating at 255
- lives  out  3  remaining lives
- game_over  out  1  high in OVER state

Behaviour:
- Reset (async, rst=1) forces the following, all registered:
  - state=IDLE, target=0, prev_target=0
  - time_left=0, score=0, lives=LIVES
  - round_active=0, result_valid=0, correct=0, game_over=0
- States: IDLE, DRAW, PLAY, SHOW, OVER.
- IDLE: start -> DRAW; score<=0, lives<=LIVES.
- DRAW: one rnd sample per cycle.
  - Accept if rnd!=0 and rnd!=prev_target.
  - Otherwise increment the try counter.
  - After DRAW_TRIES rejections, target <= prev_target+1 (mod 256); if that is 0, use 1.
  - On accept: target and prev_target load, time_left<=ROUND_TICKS, -> PLAY in the same edge.
  - Minimum DRAW latency: 1 cycle.
- PLAY: round_active=1.
  - tick decrements time_left.
  - submit: correct<=(user_value==target); -> SHOW.
  - tick with time_left==1 (reaching 0) and no submit: timeout, correct<=0, -> SHOW.
  - submit and final tick in the same cycle: submit wins; time_left is not decremented.
  - Judgement updates on the transition edge:
    - correct: score+1, saturating at 255.
    - wrong or timeout: lives-1.
- SHOW: result_valid=1; counts SHOW_TICKS ticks, then:
  - lives==0 -> OVER
  - otherwise -> DRAW
- OVER: game_over=1; target held.
  - start -> DRAW with score<=0, lives<=LIVES, prev_target kept.
- start is ignored outside IDLE/OVER.
- submit is ignored outside PLAY.
- tick is ignored in IDLE/DRAW/OVER.
- rst at any point, including mid-round or mid-SHOW, returns to IDLE with reset values on the next evaluation; no partial score is retained.
- All outputs are registered; a judgement is visible 1 cycle after the submit edge.

Optional Feature:
- Macro: ROUND_SPEEDUP_EN.
- Defined: adds register round_len (reset ROUND_TICKS).
  - Each correct answer: round_len <= max(round_len - 8, MIN_TICKS).
  - DRAW loads time_left from round_len.
  - start reloads round_len to ROUND_TICKS.
- Undefined: time_left always loads ROUND_TICKS; MIN_TICKS unused.

Decomposition:
- Shared package game_pkg:
  - state enum round_state_t {IDLE, DRAW, PLAY, SHOW, OVER}
  - localparams SCORE_MAX=8'hFF, FALLBACK_TARGET=8'h01, SPEEDUP_STEP=8
  - 8-bit width constant for number/score buses
- Sub-module tick_down_timer:
  - inputs: load, load_value, tick enable
  - outputs: count, expire pulse
  - instantiated for both PLAY and SHOW timing

Test Plan:
- Reset, then start with rnd=8'hA5, user_value=8'hA5, submit after 3 ticks:
  - target=A5 one cycle after start, round_active=1, time_left=197.
  - After submit: correct=1, score=1, lives=3, result_valid for 50 ticks.
- rnd=0 for 8 cycles in DRAW with prev_target=8'hFF -> fallback target=8'h01.
- rnd equal to prev_target (8'h4A) for 2 cycles, then 8'h95 -> target=95 after 3 DRAW cycles.
- No submit for 200 ticks -> timeout, correct=0, lives 3->2.
  - Three timeouts -> game_over=1.
  - start in OVER -> score=0, lives=3.
- submit with user_value!=target coinciding with the final tick:
  - judged wrong via the submit path, lives-1 once, time_left stays 1.
- With ROUND_SPEEDUP_EN, 20 consecutive correct answers:
  - load values 200, 192, … clamp at 40.
  - score=20.
  - Assert rst mid-PLAY -> IDLE, score=0, time_left=0.

Source files
------------

// File: rtl/round_controller_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg: shared types and constants for the binary-counting game round
// controller and its tick-down timer.
//   round_state_t   : round sequencer states
//   NUM_W           : width of number/score buses
//   SCORE_MAX       : score saturation value
//   FALLBACK_TARGET : target used when prev_target+1 wraps to zero
//   SPEEDUP_STEP    : round shortening per correct answer (ROUND_SPEEDUP_EN)
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DRAW = 3'd1,
    PLAY = 3'd2,
    SHOW = 3'd3,
    OVER = 3'd4
  } round_state_t;

  localparam int          NUM_W           = 8;
  localparam logic [7:0]  SCORE_MAX       = 8'hFF;
  localparam logic [7:0]  FALLBACK_TARGET = 8'h01;
  localparam logic [7:0]  SPEEDUP_STEP    = 8'd8;

  // Target used after too many rejected draws; zero is never a valid target.
  function automatic logic [NUM_W-1:0] fallback_target(input logic [NUM_W-1:0] prev);
    logic [NUM_W-1:0] nxt;
    nxt = prev + 8'd1;
    return (nxt == 8'd0) ? FALLBACK_TARGET : nxt;
  endfunction

  // Score increment that sticks at SCORE_MAX.
  function automatic logic [NUM_W-1:0] sat_inc(input logic [NUM_W-1:0] val);
    return (val == SCORE_MAX) ? SCORE_MAX : (val + 8'd1);
  endfunction

endpackage

// File: rtl/round_controller_tick_down_timer.sv
// -----------------------------------------------------------------------------
// tick_down_timer: loadable down-counter advanced by a tick enable.
//   clk, rst    : clock, asynchronous active-high reset (count -> 0)
//   load        : load load_value (has priority over tick)
//   load_value  : value to load
//   tick        : decrement enable; counter stops at zero
//   count       : current count (registered)
//   expire      : combinational pulse when a tick takes count from 1 to 0
// -----------------------------------------------------------------------------
module tick_down_timer
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [NUM_W-1:0] load_value,
  input  logic             tick,
  output logic [NUM_W-1:0] count,
  output logic             expire
);

  // Counter register: load wins over tick, hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != 8'd0)) begin
      count <= count - 8'd1;
    end else begin
      count <= count;
    end
  end

  assign expire = tick && !load && (count == 8'd1);

endmodule

// File: rtl/round_controller.sv
// -----------------------------------------------------------------------------
// round_controller: sequences one game of the binary-counting game.
// Draws a target from the LFSR, times the answer, judges it, keeps score and
// lives and ends the game when lives run out.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : pulse, starts a game (IDLE/OVER only)
//   tick         : timebase strobe (used in PLAY/SHOW only)
//   rnd          : current LFSR value
//   user_value   : player's switch value
//   submit       : pulse, commits user_value (PLAY only)
//   target       : current target number
//   round_active : high while an answer is accepted
//   time_left    : remaining ticks in the round
//   result_valid : high while the result is shown
//   correct      : last judgement
//   score        : correct answers this game, saturating
//   lives        : remaining lives
//   game_over    : high in OVER
// Optional feature macro: ROUND_SPEEDUP_EN (shortens each round by
// SPEEDUP_STEP ticks per correct answer, clamped at MIN_TICKS).
// -----------------------------------------------------------------------------
module round_controller
  import game_pkg::*;
#(
  parameter int LIVES       = 3,
  parameter int ROUND_TICKS = 200,
  parameter int SHOW_TICKS  = 50,
  parameter int DRAW_TRIES  = 8,
  parameter int MIN_TICKS   = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             tick,
  input  logic [NUM_W-1:0] rnd,
  input  logic [NUM_W-1:0] user_value,
  input  logic             submit,
  output logic [NUM_W-1:0] target,
  output logic             round_active,
  output logic [NUM_W-1:0] time_left,
  output logic             result_valid,
  output logic             correct,
  output logic [NUM_W-1:0] score,
  output logic [2:0]       lives,
  output logic             game_over
);

  round_state_t     state, next_state;
  logic [NUM_W-1:0] prev_target;
  logic [7:0]       tries;
  logic [NUM_W-1:0] round_load;
  logic             draw_accept, draw_fallback, judge_valid, judge_correct;
  logic             start_game, play_expire, show_expire;

`ifdef ROUND_SPEEDUP_EN
  logic [NUM_W-1:0] round_len;
  assign round_load = round_len;
`else
  assign round_load = 8'(ROUND_TICKS);
`endif

  assign start_game = start && ((state == IDLE) || (state == OVER));

  // Round timer: a submit in the same cycle freezes the count.
  tick_down_timer u_play_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (draw_accept || draw_fallback),
    .load_value (round_load),
    .tick       (tick && (state == PLAY) && !submit),
    .count      (time_left),
    .expire     (play_expire)
  );

  // Result display timer, loaded on the judgement edge.
  tick_down_timer u_show_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (judge_valid),
    .load_value (8'(SHOW_TICKS)),
    .tick       (tick && (state == SHOW)),
    .count      (),
    .expire     (show_expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and judgement decode.
  always_comb begin
    next_state    = state;
    draw_accept   = 1'b0;
    draw_fallback = 1'b0;
    judge_valid   = 1'b0;
    judge_correct = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = DRAW;
        else       next_state = IDLE;
      end
      DRAW: begin
        if ((rnd != 8'd0) && (rnd != prev_target)) begin
          draw_accept = 1'b1;
          next_state  = PLAY;
        end else if (tries == 8'(DRAW_TRIES - 1)) begin
          // This sample is the last tolerated rejection.
          draw_fallback = 1'b1;
          next_state    = PLAY;
        end else begin
          next_state = DRAW;
        end
      end
      PLAY: begin
        if (submit) begin
          judge_valid   = 1'b1;
          judge_correct = (user_value == target);
          next_state    = SHOW;
        end else if (play_expire) begin
          judge_valid   = 1'b1;
          judge_correct = 1'b0;
          next_state    = SHOW;
        end else begin
          next_state = PLAY;
        end
      end
      SHOW: begin
        if (show_expire) next_state = (lives == 3'd0) ? OVER : DRAW;
        else             next_state = SHOW;
      end
      OVER: begin
        if (start) next_state = DRAW;
        else       next_state = OVER;
      end
      default: next_state = IDLE;
    endcase
  end

  // Game datapath and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target       <= 8'd0;
      prev_target  <= 8'd0;
      score        <= 8'd0;
      lives        <= 3'(LIVES);
      correct      <= 1'b0;
      tries        <= 8'd0;
      round_active <= 1'b0;
      result_valid <= 1'b0;
      game_over    <= 1'b0;
`ifdef ROUND_SPEEDUP_EN
      round_len    <= 8'(ROUND_TICKS);
`endif
    end else begin
      round_active <= (next_state == PLAY);
      result_valid <= (next_state == SHOW);
      game_over    <= (next_state == OVER);

      if (state != DRAW) tries <= 8'd0;
      else               tries <= tries + 8'd1;

      if (draw_accept) begin
        target      <= rnd;
        prev_target <= rnd;
      end else if (draw_fallback) begin
        target      <= fallback_target(prev_target);
        prev_target <= fallback_target(prev_target);
      end

      if (start_game) begin
        score <= 8'd0;
        lives <= 3'(LIVES);
`ifdef ROUND_SPEEDUP_EN
        round_len <= 8'(ROUND_TICKS);
`endif
      end else if (judge_valid) begin
        correct <= judge_correct;
        if (judge_correct) begin
          score <= sat_inc(score);
`ifdef ROUND_SPEEDUP_EN
          // max(round_len - step, MIN_TICKS) without underflow.
          if ({1'b0, round_len} >= (9'(MIN_TICKS) + {1'b0, SPEEDUP_STEP}))
            round_len <= round_len - SPEEDUP_STEP;
          else
            round_len <= 8'(MIN_TICKS);
`endif
        end else begin
          lives <= lives - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_round_controller.sv
module tb_round_controller;

  logic       clk = 1'b0;
  logic       rst, start, tick, submit;
  logic [7:0] rnd, user_value;
  logic [7:0] target, time_left, score;
  logic       round_active, result_valid, correct, game_over;
  logic [2:0] lives;

  typedef struct {
    logic       c;
    logic [7:0] s;
    logic [2:0] l;
  } judge_t;

  judge_t sb[$];
  int     total = 0;
  int     bad   = 0;
  int     exp_len;

  round_controller dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .rnd(rnd),
    .user_value(user_value), .submit(submit), .target(target),
    .round_active(round_active), .time_left(time_left),
    .result_valid(result_valid), .correct(correct), .score(score),
    .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_judge(input bit c, input int s, input int l);
    judge_t e;
    e.c = c;
    e.s = 8'(s);
    e.l = 3'(l);
    sb.push_back(e);
  endtask

  task automatic judge(input string tag);
    judge_t e;
    chk({tag, "_rv"}, result_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_correct"}, correct, e.c);
      chk({tag, "_score"}, score, e.s);
      chk({tag, "_lives"}, lives, e.l);
    end
  endtask

  // Tick through SHOW until result_valid drops; must take exactly 50 ticks.
  task automatic finish_show(input string tag);
    int n = 0;
    tick = 1'b1;
    while (result_valid && n < 80) begin
      step;
      n++;
    end
    tick = 1'b0;
    chk({tag, "_show_ticks"}, n, 50);
  endtask

  // One DRAW sample that must be accepted.
  task automatic draw_ok(input string tag, input logic [7:0] v, input int len);
    rnd = v;
    step;
    chk({tag, "_target"}, target, v);
    chk({tag, "_active"}, round_active, 1);
    chk({tag, "_time"}, time_left, len);
  endtask

  // Let the round run out with no submit; must take exactly 200 ticks.
  task automatic run_timeout(input string tag, input int lives_after, input int score_now);
    int n = 0;
    tick = 1'b1;
    expect_judge(1'b0, score_now, lives_after);
    while (!result_valid && n < 300) begin
      step;
      n++;
    end
    chk({tag, "_round_ticks"}, n, 200);
    judge(tag);
    chk({tag, "_time0"}, time_left, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tick = 1'b0; submit = 1'b0;
    rnd = 8'h00; user_value = 8'h00;
    step; step;
    chk("rst_target", target, 0);
    chk("rst_time", time_left, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_flags", {round_active, result_valid, correct, game_over}, 0);
    rst = 1'b0;
    step;

    // Round 1: correct answer after 3 ticks.
    rnd = 8'hA5; start = 1'b1; step; start = 1'b0;
    chk("r1_draw_idle", round_active, 0);
    draw_ok("r1", 8'hA5, 200);
    tick = 1'b1; step; step; step; tick = 1'b0;
    chk("r1_time197", time_left, 197);
    user_value = 8'hA5; submit = 1'b1; expect_judge(1'b1, 1, 3);
    step; submit = 1'b0;
    judge("r1");
    chk("r1_inactive", round_active, 0);
    finish_show("r1");

    // Round 2: wrong answer, leaves prev_target = 4A.
    draw_ok("r2", 8'h4A, 200);
    user_value = 8'h00; submit = 1'b1; expect_judge(1'b0, 1, 2);
    step; submit = 1'b0;
    judge("r2");
    finish_show("r2");

    // Round 3: two repeats of prev_target rejected, then 95; timeout.
    rnd = 8'h4A; step; step;
    chk("r3_rej_active", round_active, 0);
    chk("r3_rej_target", target, 8'h4A);
    draw_ok("r3", 8'h95, 200);
    run_timeout("r3", 1, 1);
    finish_show("r3");

    // Round 4: wrong submit together with the final tick.
    draw_ok("r4", 8'h33, 200);
    tick = 1'b1;
    for (int i = 0; i < 199; i++) step;
    chk("r4_time1", time_left, 1);
    user_value = 8'h00; submit = 1'b1; expect_judge(1'b0, 1, 0);
    step; submit = 1'b0; tick = 1'b0;
    judge("r4");
    chk("r4_time_held", time_left, 1);
    finish_show("r4");
    chk("r4_over", game_over, 1);
    chk("r4_target_held", target, 8'h33);
    rnd = 8'h55; step;
    chk("r4_over_stays", game_over, 1);

    // New game from OVER; three timeouts including the fallback draw.
    start = 1'b1; step; start = 1'b0;
    chk("g2_score", score, 0);
    chk("g2_lives", lives, 3);
    chk("g2_not_over", game_over, 0);
    draw_ok("g2a", 8'hFF, 200);
    run_timeout("g2a", 2, 0);
    finish_show("g2a");
    rnd = 8'h00;
    for (int i = 0; i < 7; i++) step;
    chk("fb_waiting", round_active, 0);
    step;
    chk("fb_target", target, 8'h01);
    chk("fb_active", round_active, 1);
    run_timeout("g2b", 1, 0);
    finish_show("g2b");
    draw_ok("g2c", 8'h77, 200);
    run_timeout("g2c", 0, 0);
    finish_show("g2c");
    chk("g2_over", game_over, 1);
    start = 1'b1; step; start = 1'b0;
    chk("g3_score", score, 0);
    chk("g3_lives", lives, 3);

    // Twenty consecutive correct answers; round length model.
    exp_len = 200;
    for (int i = 0; i < 20; i++) begin
      draw_ok("spd", 8'(8'h10 + i * 7), exp_len);
      user_value = target; submit = 1'b1; expect_judge(1'b1, i + 1, 3);
      step; submit = 1'b0;
      judge("spd");
`ifdef ROUND_SPEEDUP_EN
      exp_len = (exp_len - 8 < 40) ? 40 : exp_len - 8;
`endif
      finish_show("spd");
    end
    chk("spd_score20", score, 20);

    // Reset in the middle of PLAY.
    draw_ok("mid", 8'hC3, exp_len);
    tick = 1'b1; step; step; tick = 1'b0;
    rst = 1'b1; #1;
    chk("mid_rst_score", score, 0);
    chk("mid_rst_time", time_left, 0);
    chk("mid_rst_lives", lives, 3);
    chk("mid_rst_flags", {round_active, result_valid, game_over}, 0);
    step; rst = 1'b0; step;
    chk("mid_idle", round_active, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
